stopwatch_display: RTL

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

---
 rtl/stopwatch_display.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM.SS display driver for a stopwatch.
// The minutes/seconds pair is captured once per full scan so a scan never mixes
// two different values, and all display outputs are registered.
module stopwatch_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] minutes,
   input  logic [7:0] seconds,
   input  logic       blank,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int unsigned CW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned VW  = 8;
   localparam int unsigned SW  = 7;
   localparam int unsigned AW  = 4;

   localparam logic [SW-1:0] SEG_OFF  = 7'h7F;
   localparam logic [SW-1:0] SEG_DASH = 7'b0111111;
   localparam logic [AW-1:0] AN_OFF   = 4'b1111;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [VW-1:0] min_q, min_d;
   logic [VW-1:0] sec_q, sec_d;
   logic [SW-1:0] seg_d;
   logic [AW-1:0] an_d;
   logic          dp_d;

   logic          wrap;
   logic          guard;
   logic          pair_hi;
   logic          pair_bad;
   logic [VW-1:0] pair_val;
   logic [3:0]    digit;

   // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit
   function automatic logic [SW-1:0] encode(input logic [3:0] d);
      logic [SW-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // Refresh counter, digit index and once-per-scan snapshot
   always_comb begin
      wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      min_d = min_q;
      sec_d = sec_q;
      if (wrap) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            min_d = minutes;
            sec_d = seconds;
         end
      end
   end

   // Digit selection: index 0/1 = seconds ones/tens, 2/3 = minutes ones/tens
   always_comb begin
      pair_hi  = idx_q[1];
      pair_val = pair_hi ? min_q : sec_q;
      pair_bad = pair_hi ? (min_q > 8'd99) : (sec_q > 8'd59);
      digit    = idx_q[0] ? 4'(pair_val / 8'd10) : 4'(pair_val % 8'd10);
   end

   // Next display outputs: guard blanks only the anode, blank forces everything off
   always_comb begin
      guard = (cnt_q < CW'(GUARD));
      seg_d = pair_bad ? SEG_DASH : encode(digit);
      an_d  = guard ? AN_OFF : ~(4'b0001 << idx_q);
      dp_d  = ~((idx_q == 2'd2) && !guard);
      if (blank) begin
         seg_d = SEG_OFF;
         an_d  = AN_OFF;
         dp_d  = 1'b1;
      end
   end

   // Scan state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         min_q <= '0;
         sec_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   // Registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
         dp  <= 1'b1;
      end else begin
         seg <= seg_d;
         an  <= an_d;
         dp  <= dp_d;
      end
   end

endmodule
